// File: rtl/led7seg_disp_arbiter.sv
// ---------------------------------------------------------------------------
// led7seg_disp_arbiter
//
// Shares the single 16-bit (4 hex digit) 7-segment display data bus among
// four requesters. The arbiter is round-robin, and each grant is held for a
// minimum time so that the value on the display stays readable before the
// display switches to another requester. The output drives the data input
// of the LED7Seg scanner.
//
// State table:
//   state  | meaning
//   IDLE   | nothing granted, disp_data shows IDLE_DATA
//   HOLD   | one requester granted, hold_cnt counting toward HOLD_CYCLES-1
//
// Parameters:
//   HOLD_CYCLES  minimum cycles a grant is kept while others wait (1..2**24)
//   IDLE_DATA    value shown on disp_data while nothing is granted
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   req        req[i]=1: requester i wants the display (level)
//   req_data   requester i data on req_data[16*i+15:16*i]
//   gnt        one-hot grant, or 4'b0000 when idle (registered)
//   gnt_valid  |gnt (registered)
//   disp_data  data for the 7-seg scanner (registered)
// ---------------------------------------------------------------------------
module led7seg_disp_arbiter #(
    parameter int unsigned HOLD_CYCLES = 32'd4194304,
    parameter logic [15:0] IDLE_DATA   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] req_data,
    output logic [3:0]  gnt,
    output logic        gnt_valid,
    output logic [15:0] disp_data
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  gidx, gidx_nxt;
    logic [1:0]  rr_ptr, rr_ptr_nxt;
    logic [23:0] hold_cnt, hold_cnt_nxt;
    logic [3:0]  gnt_nxt;
    logic [3:0]  others;
    logic [1:0]  pick_idx;
    logic [15:0] disp_nxt;

    // First set bit of mask scanning start, start+1, ... (mod 4). The loop
    // runs downward so the candidate closest to start is written last.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask,
                                           input logic [1:0] start);
        logic [1:0] idx;
        rr_pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (mask[idx]) rr_pick = idx;
        end
    endfunction

    // Requesters competing with the current holder.
    assign others = req & ~gnt;

    // Scan origin is rr_ptr from IDLE and g+1 while holding; both are equal
    // whenever a grant exists, since rr_ptr is updated on every new grant.
    assign pick_idx = (state == S_IDLE) ? rr_pick(req, rr_ptr)
                                        : rr_pick(others, gidx + 2'd1);

    always_comb begin
        state_nxt    = state;
        gidx_nxt     = gidx;
        rr_ptr_nxt   = rr_ptr;
        hold_cnt_nxt = hold_cnt;
        gnt_nxt      = gnt;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_nxt    = S_HOLD;
                    gidx_nxt     = pick_idx;
                    gnt_nxt      = 4'b0001 << pick_idx;
                    rr_ptr_nxt   = pick_idx + 2'd1;
                    hold_cnt_nxt = '0;
                end
            end
            S_HOLD: begin
                // Release wins over expiry; with req[g] low, others == req.
                if (!req[gidx]) begin
                    hold_cnt_nxt = '0;
                    if (|others) begin
                        gidx_nxt   = pick_idx;
                        gnt_nxt    = 4'b0001 << pick_idx;
                        rr_ptr_nxt = pick_idx + 2'd1;
                    end else begin
                        state_nxt = S_IDLE;
                        gnt_nxt   = '0;
                    end
                end else if (hold_cnt == HOLD_LAST && |others) begin
                    hold_cnt_nxt = '0;
                    gidx_nxt     = pick_idx;
                    gnt_nxt      = 4'b0001 << pick_idx;
                    rr_ptr_nxt   = pick_idx + 2'd1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + 24'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // Display follows the grant that was valid during this cycle, so a new
    // grant shows the old slice for one cycle before its own data appears.
    assign disp_nxt = (|gnt) ? req_data[16*gidx +: 16] : IDLE_DATA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gidx      <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            disp_data <= IDLE_DATA;
        end else begin
            state     <= state_nxt;
            gidx      <= gidx_nxt;
            rr_ptr    <= rr_ptr_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= |gnt_nxt;
            disp_data <= disp_nxt;
        end
    end

endmodule
